axi2core_slave: RTL and testbench

//   AXI4 slave that turns AXI read/write bursts into single-word transfers on the core-side data interface (req/gnt/rvalid) towards a 32-bit memory or peripheral.
//   It is the responder counterpart of the core-to-AXI bridge: it sits behind the AXI interconnect in front of on-chip RAM or a register bank.

---
 rtl/axi2core_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi2core_slave.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2core_slave.sv
// AXI4 slave that serialises read/write bursts into single-word req/gnt/rvalid
// accesses on a 32-bit core-side memory port. One transaction, one access in flight.
module axi2core_slave #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_ID_WIDTH      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,

   input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
   input  logic [7:0]                    aw_len_i,
   input  logic [2:0]                    aw_size_i,
   input  logic [1:0]                    aw_burst_i,
   input  logic                          aw_valid_i,
   output logic                          aw_ready_o,

   input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
   input  logic [7:0]                    ar_len_i,
   input  logic [2:0]                    ar_size_i,
   input  logic [1:0]                    ar_burst_i,
   input  logic                          ar_valid_i,
   output logic                          ar_ready_o,

   input  logic [31:0]                   w_data_i,
   input  logic [3:0]                    w_strb_i,
   input  logic                          w_last_i,
   input  logic                          w_valid_i,
   output logic                          w_ready_o,

   output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
   output logic [1:0]                    b_resp_o,
   output logic                          b_valid_o,
   input  logic                          b_ready_i,

   output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
   output logic [31:0]                   r_data_o,
   output logic [1:0]                    r_resp_o,
   output logic                          r_last_o,
   output logic                          r_valid_o,
   input  logic                          r_ready_i,

   output logic                          data_req_o,
   input  logic                          data_gnt_i,
   input  logic                          data_rvalid_i,
   output logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_o,
   output logic                          data_we_o,
   output logic [3:0]                    data_be_o,
   output logic [31:0]                   data_wdata_o,
   input  logic [31:0]                   data_rdata_i
);

   localparam int AW = AXI4_ADDRESS_WIDTH;

   localparam logic [1:0]    RESP_OKAY   = 2'b00;
   localparam logic [1:0]    RESP_SLVERR = 2'b10;
   localparam logic [1:0]    BURST_FIXED = 2'b00;
   localparam logic [1:0]    BURST_WRAP  = 2'b10;
   localparam logic [2:0]    SIZE_WORD   = 3'b010;
   localparam logic [AW-1:0] WORD_MASK   = ~AW'(3);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      RD_RESP,
      WR_DATA,
      WR_REQ,
      WR_WAIT,
      WR_RESP
   } state_e;

   state_e        state;
   logic          prio_rd;
   logic [7:0]    len_q;
   logic [7:0]    cnt_q;
   logic          fixed_q;
   logic          err_q;
   logic          wlast_err_q;

   logic          pick_rd;
   logic          pick_wr;
   logic          ar_err;
   logic          aw_err;
   logic          last_beat;
   logic [AW-1:0] next_addr;

   assign ar_err    = (ar_size_i != SIZE_WORD) || (ar_burst_i == BURST_WRAP);
   assign aw_err    = (aw_size_i != SIZE_WORD) || (aw_burst_i == BURST_WRAP);
   assign last_beat = (cnt_q == len_q);
   assign next_addr = fixed_q ? data_addr_o : data_addr_o + AW'(4);

   // Address ready is offered to one channel only; the pointer breaks ties.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pick_rd = 1'b0;
      pick_wr = 1'b0;
      if (state == IDLE && !rst_i) begin
         if (ar_valid_i && (!aw_valid_i || prio_rd))
            pick_rd = 1'b1;
         else if (aw_valid_i)
            pick_wr = 1'b1;
      end
   end

   assign ar_ready_o = pick_rd;
   assign aw_ready_o = pick_wr;

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         prio_rd      <= 1'b1;
         len_q        <= '0;
         cnt_q        <= '0;
         fixed_q      <= 1'b0;
         err_q        <= 1'b0;
         wlast_err_q  <= 1'b0;
         w_ready_o    <= 1'b0;
         b_id_o       <= '0;
         b_resp_o     <= RESP_OKAY;
         b_valid_o    <= 1'b0;
         r_id_o       <= '0;
         r_data_o     <= '0;
         r_resp_o     <= RESP_OKAY;
         r_last_o     <= 1'b0;
         r_valid_o    <= 1'b0;
         data_req_o   <= 1'b0;
         data_addr_o  <= '0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_wdata_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_rd) begin
                  prio_rd     <= 1'b0;
                  r_id_o      <= ar_id_i;
                  len_q       <= ar_len_i;
                  cnt_q       <= '0;
                  fixed_q     <= (ar_burst_i == BURST_FIXED);
                  err_q       <= ar_err;
                  data_addr_o <= ar_addr_i & WORD_MASK;
                  data_we_o   <= 1'b0;
                  if (ar_err) begin
                     // Rejected reads skip memory and answer SLVERR beats directly.
                     r_valid_o <= 1'b1;
                     r_data_o  <= '0;
                     r_resp_o  <= RESP_SLVERR;
                     r_last_o  <= (ar_len_i == 8'd0);
                     state     <= RD_RESP;
                  end else begin
                     data_req_o <= 1'b1;
                     state      <= RD_REQ;
                  end
               end else if (pick_wr) begin
                  prio_rd     <= 1'b1;
                  b_id_o      <= aw_id_i;
                  len_q       <= aw_len_i;
                  cnt_q       <= '0;
                  fixed_q     <= (aw_burst_i == BURST_FIXED);
                  err_q       <= aw_err;
                  wlast_err_q <= 1'b0;
                  data_addr_o <= aw_addr_i & WORD_MASK;
                  data_we_o   <= 1'b1;
                  w_ready_o   <= 1'b1;
                  state       <= WR_DATA;
               end
            end

            RD_REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state      <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (data_rvalid_i) begin
                  r_data_o  <= data_rdata_i;
                  r_resp_o  <= RESP_OKAY;
                  r_last_o  <= last_beat;
                  r_valid_o <= 1'b1;
                  state     <= RD_RESP;
               end
            end

            RD_RESP: begin
               if (r_ready_i) begin
                  r_valid_o <= 1'b0;
                  r_last_o  <= 1'b0;
                  if (last_beat) begin
                     state <= IDLE;
                  end else begin
                     cnt_q       <= cnt_q + 8'd1;
                     data_addr_o <= next_addr;
                     if (err_q) begin
                        r_valid_o <= 1'b1;
                        r_last_o  <= (cnt_q + 8'd1 == len_q);
                     end else begin
                        data_req_o <= 1'b1;
                        state      <= RD_REQ;
                     end
                  end
               end
            end

            WR_DATA: begin
               if (w_valid_i) begin
                  data_be_o    <= w_strb_i;
                  data_wdata_o <= w_data_i;
                  // The beat count follows len; a misplaced w_last only poisons the response.
                  if (w_last_i != last_beat)
                     wlast_err_q <= 1'b1;
                  if (err_q) begin
                     if (last_beat) begin
                        w_ready_o <= 1'b0;
                        b_resp_o  <= RESP_SLVERR;
                        b_valid_o <= 1'b1;
                        state     <= WR_RESP;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end else begin
                     w_ready_o  <= 1'b0;
                     data_req_o <= 1'b1;
                     state      <= WR_REQ;
                  end
               end
            end

            WR_REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state      <= WR_WAIT;
               end
            end

            WR_WAIT: begin
               if (data_rvalid_i) begin
                  if (last_beat) begin
                     b_resp_o  <= wlast_err_q ? RESP_SLVERR : RESP_OKAY;
                     b_valid_o <= 1'b1;
                     state     <= WR_RESP;
                  end else begin
                     cnt_q       <= cnt_q + 8'd1;
                     data_addr_o <= next_addr;
                     w_ready_o   <= 1'b1;
                     state       <= WR_DATA;
                  end
               end
            end

            WR_RESP: begin
               if (b_ready_i) begin
                  b_valid_o <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi2core_slave.sv
// Directed bench for axi2core_slave with a small req/gnt/rvalid memory model.
module tb_axi2core_slave;

   localparam int AW = 32;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic [IW-1:0] aw_id = '0,  ar_id = '0;
   logic [AW-1:0] aw_addr = '0, ar_addr = '0;
   logic [7:0]    aw_len = '0, ar_len = '0;
   logic [2:0]    aw_size = 3'b010, ar_size = 3'b010;
   logic [1:0]    aw_burst = 2'b01, ar_burst = 2'b01;
   logic          aw_valid = 1'b0, ar_valid = 1'b0;
   logic          aw_ready, ar_ready;
   logic [31:0]   w_data = '0;
   logic [3:0]    w_strb = '0;
   logic          w_last = 1'b0, w_valid = 1'b0;
   logic          w_ready;
   logic [IW-1:0] b_id, r_id;
   logic [1:0]    b_resp, r_resp;
   logic          b_valid, r_valid, r_last;
   logic          b_ready = 1'b0, r_ready = 1'b0;
   logic [31:0]   r_data;
   logic          data_req, data_we;
   logic          data_gnt = 1'b0, data_rvalid = 1'b0;
   logic [AW-1:0] data_addr;
   logic [3:0]    data_be;
   logic [31:0]   data_wdata;
   logic [31:0]   data_rdata = '0;

   always #5 clk = ~clk;

   axi2core_slave #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_ID_WIDTH(IW)) dut (
      .clk_i(clk), .rst_i(rst),
      .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
      .aw_burst_i(aw_burst), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
      .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
      .ar_burst_i(ar_burst), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
      .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid),
      .w_ready_o(w_ready),
      .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
      .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
      .r_valid_o(r_valid), .r_ready_i(r_ready),
      .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
      .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be),
      .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: grant after gnt_delay cycles of req, respond the cycle after grant.
   logic [31:0] mem [0:255];
   int          gnt_delay = 0;
   int          wait_cnt  = 0;
   int          req_count = 0;
   logic        g_we = 1'b0;
   logic [31:0] g_addr = '0;
   logic [31:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   logic [3:0]  wr_be_q   [$];
   logic [31:0] rd_addr_q [$];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      mem[8'h40] = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         data_rvalid = 1'b0;
         if (rst) begin
            data_gnt = 1'b0;
            wait_cnt = 0;
         end else if (data_gnt) begin
            data_gnt    = 1'b0;
            data_rvalid = 1'b1;
            data_rdata  = g_we ? 32'h0 : mem[g_addr[9:2]];
         end else if (data_req) begin
            if (wait_cnt == gnt_delay) begin
               data_gnt = 1'b1;
               wait_cnt = 0;
               req_count++;
               g_we   = data_we;
               g_addr = data_addr;
               if (data_we) begin
                  wr_addr_q.push_back(data_addr);
                  wr_data_q.push_back(data_wdata);
                  wr_be_q.push_back(data_be);
                  for (int k = 0; k < 4; k++)
                     if (data_be[k]) mem[data_addr[9:2]][8*k +: 8] = data_wdata[8*k +: 8];
               end else begin
                  rd_addr_q.push_back(data_addr);
               end
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic ar_send(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bit hs = 1'b0;
      @(posedge clk); #1;
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ar_ready) begin hs = 1'b1; break; end
      end
      check("ar_hs", hs, 1);
      @(posedge clk); #1;
      ar_valid = 1'b0;
   endtask

   task automatic aw_send(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bit hs = 1'b0;
      @(posedge clk); #1;
      aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (aw_ready) begin hs = 1'b1; break; end
      end
      check("aw_hs", hs, 1);
      @(posedge clk); #1;
      aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      bit hs = 1'b0;
      @(posedge clk); #1;
      w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (w_ready) begin hs = 1'b1; break; end
      end
      check("w_hs", hs, 1);
      @(posedge clk); #1;
      w_valid = 1'b0;
   endtask

   task automatic r_recv(input string tag, input logic [IW-1:0] id, input logic [31:0] data,
                         input logic [1:0] resp, input logic last, input int stall);
      bit          seen = 1'b0;
      logic [50:0] snap;
      r_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (r_valid) begin seen = 1'b1; break; end
      end
      check({tag, "_valid"}, seen, 1);
      if (stall > 0) begin
         snap = {r_id, r_data, r_resp, r_last};
         repeat (stall) @(negedge clk);
         check({tag, "_stable"}, {r_valid, r_id, r_data, r_resp, r_last}, {1'b1, snap});
      end
      check({tag, "_data"}, r_data, data);
      check({tag, "_id_resp_last"}, {r_id, r_resp, r_last}, {id, resp, last});
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
   endtask

   task automatic b_recv(input string tag, input logic [IW-1:0] id, input logic [1:0] resp);
      bit seen = 1'b0;
      b_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b_valid) begin seen = 1'b1; break; end
      end
      check({tag, "_valid"}, seen, 1);
      check({tag, "_id_resp"}, {b_id, b_resp}, {id, resp});
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int rc0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", {ar_ready, aw_ready, w_ready, r_valid, b_valid, data_req, data_we}, 0);
      check("rst_regs", {r_data, data_addr}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single-beat read: latency and payload
      ar_send(16'h1234, 32'h100, 8'd0, 3'b010, 2'b01);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!r_valid && cyc < 20);
      check("rd_latency", cyc, 3);
      r_recv("rd1", 16'h1234, 32'hDEAD_BEEF, 2'b00, 1'b1, 0);

      // Four-beat INCR write
      wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
      aw_send(16'h0BEE, 32'h200, 8'd3, 3'b010, 2'b01);
      for (int b = 0; b < 4; b++) w_send(32'hC0DE_0000 + b, 4'hF, b == 3);
      b_recv("wr4_b", 16'h0BEE, 2'b00);
      check("wr4_count", wr_addr_q.size(), 4);
      for (int b = 0; b < 4; b++) begin
         check($sformatf("wr4_addr%0d", b), wr_addr_q[b], 32'h200 + 4 * b);
         check($sformatf("wr4_data%0d", b), {wr_be_q[b], wr_data_q[b]}, {4'hF, 32'hC0DE_0000 + b});
      end

      // Simultaneous AR/AW twice: read first, then write, then the re-issued read
      @(posedge clk); #1;
      ar_id = 16'd3; ar_addr = 32'h300; ar_len = 8'd0; ar_size = 3'b010; ar_burst = 2'b01; ar_valid = 1'b1;
      aw_id = 16'd4; aw_addr = 32'h240; aw_len = 8'd0; aw_size = 3'b010; aw_burst = 2'b01; aw_valid = 1'b1;
      @(negedge clk);
      check("arb1", {ar_ready, aw_ready}, 2'b10);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      r_recv("arb_rd", 16'd3, 32'hA500_00C0, 2'b00, 1'b1, 0);
      ar_addr = 32'h304; ar_valid = 1'b1;
      @(negedge clk);
      check("arb2", {ar_ready, aw_ready}, 2'b01);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
      w_send(32'h5555_AAAA, 4'hF, 1'b1);
      b_recv("arb_b", 16'd4, 2'b00);
      check("arb_wr_addr", wr_addr_q[0], 32'h240);
      @(negedge clk);
      check("arb3", {ar_ready, aw_ready}, 2'b10);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      r_recv("arb_rd2", 16'd3, 32'hA500_00C1, 2'b00, 1'b1, 0);

      // Illegal size read: SLVERR beats, no memory traffic
      rc0 = req_count;
      ar_send(16'd5, 32'h100, 8'd1, 3'b011, 2'b01);
      r_recv("err0", 16'd5, 32'h0, 2'b10, 1'b0, 0);
      r_recv("err1", 16'd5, 32'h0, 2'b10, 1'b1, 0);
      check("err_noreq", req_count, rc0);

      // Delayed grant plus stalled R channel
      gnt_delay = 3;
      rc0 = req_count;
      ar_send(16'd6, 32'h104, 8'd0, 3'b010, 2'b01);
      r_recv("stall", 16'd6, 32'hA500_0041, 2'b00, 1'b1, 5);
      check("stall_reqs", req_count, rc0 + 1);
      gnt_delay = 0;

      // FIXED read burst keeps the address
      rd_addr_q.delete();
      ar_send(16'd7, 32'h10A, 8'd1, 3'b010, 2'b00);
      r_recv("fix0", 16'd7, 32'hA500_0042, 2'b00, 1'b0, 0);
      r_recv("fix1", 16'd7, 32'hA500_0042, 2'b00, 1'b1, 0);
      check("fix_addrs", {rd_addr_q.size(), rd_addr_q[0], rd_addr_q[1]}, {32'd2, 32'h108, 32'h108});

      // Early w_last: both beats still written, B is SLVERR
      wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
      aw_send(16'd8, 32'h2F0, 8'd1, 3'b010, 2'b01);
      w_send(32'h1111_1111, 4'hF, 1'b1);
      w_send(32'h2222_2222, 4'h3, 1'b1);
      b_recv("wlast_b", 16'd8, 2'b10);
      check("wlast_count", wr_addr_q.size(), 2);
      check("wlast_beat1", {wr_addr_q[1], wr_be_q[1], wr_data_q[1]}, {32'h2F4, 4'h3, 32'h2222_2222});

      // WRAP write: W beats drained, nothing written
      rc0 = req_count;
      aw_send(16'd9, 32'h200, 8'd1, 3'b010, 2'b10);
      w_send(32'h3333_3333, 4'hF, 1'b0);
      w_send(32'h4444_4444, 4'hF, 1'b1);
      b_recv("wrap_b", 16'd9, 2'b10);
      check("wrap_noreq", req_count, rc0);

      // Reset in the middle of a write burst
      aw_send(16'd10, 32'h280, 8'd3, 3'b010, 2'b01);
      w_send(32'h6666_0000, 4'hF, 1'b0);
      w_send(32'h6666_0001, 4'hF, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ctrl", {ar_ready, aw_ready, w_ready, r_valid, b_valid, data_req, data_we}, 0);
      check("midrst_regs", {data_addr, b_id, data_wdata}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_no_b", {b_valid, w_ready}, 0);
      ar_send(16'd11, 32'h100, 8'd0, 3'b010, 2'b01);
      r_recv("post_rst", 16'd11, 32'hDEAD_BEEF, 2'b00, 1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
